// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: serialises 8/16/32-bit loads and stores from NUM_CH requesters
// onto a byte-wide RAM/IO bus. Round-robin arbitration (ch0 wins first after reset),
// IO write back-pressure, selective read abort on flush, one-hot response strobes.
//
// Build option: define MEM_ARB_STRICT_PRIO_EN for fixed priority (lowest channel
// index wins, no round-robin pointer). Default build is round-robin.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (0 = freeze all state)
//   mem_din/mem_dout/mem_a/mem_wr   byte bus; read data valid the cycle after address
//   io_buffer_full                  stalls writes to addr[17:16]==2'b11
//   flush_in                        aborts reads of FLUSH_MASK channels, blocks grants
//   req_*                           per-channel request, held until resp_valid
//   resp_valid/resp_data            one-hot done strobe, load result
//   busy_out/grant_ch_out           transfer in progress / owning channel
module mem_arbiter_nch #(
  parameter int                NUM_CH     = 2,
  parameter int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = '1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  flush_in,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_wr,
  input  logic [2*NUM_CH-1:0]   req_size,
  input  logic [NUM_CH-1:0]     req_sext,
  input  logic [32*NUM_CH-1:0]  req_addr,
  input  logic [32*NUM_CH-1:0]  req_wdata,
  output logic [NUM_CH-1:0]     resp_valid,
  output logic [31:0]           resp_data,
  output logic                  busy_out,
  output logic [CH_W-1:0]       grant_ch_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_e;

  localparam int unsigned NCH = unsigned'(NUM_CH);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               sext_q, sext_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        mem_a_q, mem_a_d;
  logic [7:0]         mem_dout_q, mem_dout_d;
  logic               mem_wr_q, mem_wr_d;
  logic [NUM_CH-1:0]  resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic               busy_q, busy_d;
`ifndef MEM_ARB_STRICT_PRIO_EN
  logic [CH_W-1:0]    rr_q, rr_d;
`endif

  logic [31:0]        addr_a  [NUM_CH];
  logic [31:0]        wdata_a [NUM_CH];
  logic [1:0]         size_a  [NUM_CH];
  logic [NUM_CH-1:0]  eligible;
  logic               gnt_found;
  logic [CH_W-1:0]    gnt_idx;
  logic [2:0]         last_idx;
  logic               io_stall;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[32*g +: 32];
    assign wdata_a[g] = req_wdata[32*g +: 32];
    assign size_a[g]  = req_size[2*g +: 2];
  end

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic sx);
    case (sz)
      2'b00:   extend = {{24{sx & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{sx & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign last_idx = (size_q == 2'b00) ? 3'd0 : (size_q == 2'b01) ? 3'd1 : 3'd3;
  assign io_stall = (mem_a_q[17:16] == 2'b11) && io_buffer_full;

  assign mem_wr       = mem_wr_q & rdy_in & ~io_stall;
  assign mem_dout     = mem_dout_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign busy_out     = busy_q;
  assign grant_ch_out = ch_q;

  // While frozen, point the bus back at the byte awaiting capture so that the
  // data presented on the first ready cycle belongs to it.
  assign mem_a = (!rdy_in && state_q == ST_RD && cnt_q != 3'd0)
                 ? addr_q + {29'd0, cnt_q} - 32'd1 : mem_a_q;

  // Arbitration; the channel being answered this cycle cannot win again.
  always_comb begin
    int unsigned c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    eligible  = req_valid & ~resp_valid_q;
`ifdef MEM_ARB_STRICT_PRIO_EN
    for (int unsigned k = 0; k < NCH; k++) begin
      c = k;
      if (!gnt_found && eligible[CH_W'(c)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
      end
    end
`else
    for (int unsigned k = 1; k <= NCH; k++) begin
      c = (32'(rr_q) + k) % NCH;
      if (!gnt_found && eligible[CH_W'(c)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
      end
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    sext_d       = sext_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    busy_d       = busy_q;
`ifndef MEM_ARB_STRICT_PRIO_EN
    rr_d         = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        mem_wr_d = 1'b0;
        if (!flush_in && gnt_found) begin
          ch_d    = gnt_idx;
          addr_d  = addr_a[gnt_idx];
          wdata_d = wdata_a[gnt_idx];
          size_d  = size_a[gnt_idx];
          sext_d  = req_sext[gnt_idx];
          cnt_d   = 3'd0;
          data_d  = '0;
          busy_d  = 1'b1;
          mem_a_d = addr_a[gnt_idx];
`ifndef MEM_ARB_STRICT_PRIO_EN
          rr_d    = gnt_idx;
`endif
          if (req_wr[gnt_idx]) begin
            state_d    = ST_WR;
            mem_dout_d = wdata_a[gnt_idx][7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      // cnt_q counts cycles since grant: byte cnt_q-1 is on mem_din, byte cnt_q
      // (if any) is addressed.
      ST_RD: begin
        if (flush_in && FLUSH_MASK[ch_q]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (cnt_q != 3'd0) data_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
          if (cnt_q == last_idx + 3'd1) begin
            state_d              = ST_IDLE;
            busy_d               = 1'b0;
            resp_valid_d[ch_q]   = 1'b1;
            resp_data_d          = extend(data_d, size_q, sext_q);
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q < last_idx) mem_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
          end
        end
      end
      ST_WR: begin
        if (!io_stall) begin
          if (cnt_q == last_idx) begin
            state_d            = ST_IDLE;
            busy_d             = 1'b0;
            mem_wr_d           = 1'b0;
            resp_valid_d[ch_q] = 1'b1;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            mem_a_d    = addr_q + {29'd0, cnt_q} + 32'd1;
            mem_dout_d = wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      sext_q       <= 1'b0;
      cnt_q        <= '0;
      data_q       <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
`ifndef MEM_ARB_STRICT_PRIO_EN
      rr_q         <= CH_W'(NUM_CH - 1);
`endif
    end else if (rdy_in) begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
`ifndef MEM_ARB_STRICT_PRIO_EN
      rr_q         <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
module tb_mem_arbiter_nch;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush_in;
  logic [1:0]  req_valid, req_wr, req_sext;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        busy_out;
  logic [0:0]  grant_ch_out;

  logic [31:0] a_arr [2];
  logic [31:0] w_arr [2];
  logic [1:0]  s_arr [2];
  assign req_addr  = {a_arr[1], a_arr[0]};
  assign req_wdata = {w_arr[1], w_arr[0]};
  assign req_size  = {s_arr[1], s_arr[0]};

  mem_arbiter_nch #(.NUM_CH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .flush_in(flush_in),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy_out(busy_out), .grant_ch_out(grant_ch_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [7:0] ram [0:262143];
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        ch;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] last_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push(input logic ch, input logic [31:0] d, input int unsigned c);
    sb.push_back('{ch, d, c});
  endtask

  // Monitor: every strobe must match the oldest expected response.
  always @(negedge clk_in) begin
    if (rst_in && resp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid %b expected none (cycle %0d)",
                 resp_valid, cyc);
      end else begin
        e = sb.pop_front();
        check("resp_ch", {30'd0, resp_valid}, {30'd0, e.ch, ~e.ch});
        check("resp_data", resp_data, e.data);
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic start_of(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic at_cyc(input int unsigned t);
    @(negedge clk_in);
    while (cyc < t) @(negedge clk_in);
  endtask

  task automatic set_req(input logic ch, input logic wr, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
    req_valid[ch] = 1'b1;
    req_wr[ch]    = wr;
    req_sext[ch]  = sx;
    s_arr[ch]     = sz;
    a_arr[ch]     = a;
    w_arr[ch]     = wd;
  endtask

  task automatic clr_req(input logic ch);
    req_valid[ch] = 1'b0;
  endtask

  task automatic load(input logic ch, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] expv, input int unsigned lat);
    int unsigned c0;
    c0 = cyc;
    set_req(ch, 1'b0, sz, sx, a, 32'd0);
    push(ch, expv, c0 + lat);
    start_of(c0 + lat + 1);
    clr_req(ch);
    last_data = expv;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_grant", {31'd0, grant_ch_out}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned c0;
    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_in = 1'b0;
    req_valid = '0; req_wr = '0; req_sext = '0;
    for (int i = 0; i < 2; i++) begin a_arr[i] = '0; w_arr[i] = '0; s_arr[i] = '0; end
    last_data = 32'd0;
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
    ram[18'h104] = 8'h55; ram[18'h105] = 8'h66; ram[18'h106] = 8'h77; ram[18'h107] = 8'h88;
    ram[18'h200] = 8'h80; ram[18'h202] = 8'h01; ram[18'h203] = 8'h80;

    start_of(2);
    check_reset_outputs();
    rst_in = 1'b1;
    start_of(4);

    // LW ch0
    c0 = cyc;
    set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    push(1'b0, 32'h44332211, c0 + 6);
    at_cyc(c0 + 1);
    check("lw_busy_c1", {31'd0, busy_out}, 32'd1);
    check("lw_grant_c1", {31'd0, grant_ch_out}, 32'd0);
    check("lw_addr_c1", mem_a, 32'h100);
    check("lw_wr_c1", {31'd0, mem_wr}, 32'd0);
    at_cyc(c0 + 5);
    check("lw_busy_c5", {31'd0, busy_out}, 32'd1);
    at_cyc(c0 + 6);
    check("lw_busy_c6", {31'd0, busy_out}, 32'd0);
    start_of(c0 + 7);
    clr_req(1'b0);
    last_data = 32'h44332211;

    // byte/half loads on ch1
    load(1'b1, 2'b00, 1'b1, 32'h200, 32'hFFFFFF80, 3);
    load(1'b1, 2'b00, 1'b0, 32'h200, 32'h00000080, 3);
    load(1'b1, 2'b01, 1'b1, 32'h202, 32'hFFFF8001, 4);

    // both channels request continuously: grants alternate 0,1,0,1
    c0 = cyc;
    set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'd0);
    push(1'b0, 32'h44332211, c0 + 6);
    push(1'b1, 32'h88776655, c0 + 12);
    push(1'b0, 32'h44332211, c0 + 18);
    push(1'b1, 32'h88776655, c0 + 24);
    fork
      begin start_of(c0 + 19); clr_req(1'b0); end
      begin start_of(c0 + 25); clr_req(1'b1); end
      begin
        at_cyc(c0 + 1);  check("rr_grant_a", {31'd0, grant_ch_out}, 32'd0);
        at_cyc(c0 + 7);  check("rr_grant_b", {31'd0, grant_ch_out}, 32'd1);
        at_cyc(c0 + 13); check("rr_grant_c", {31'd0, grant_ch_out}, 32'd0);
        at_cyc(c0 + 19); check("rr_grant_d", {31'd0, grant_ch_out}, 32'd1);
        check("rr_busy_d", {31'd0, busy_out}, 32'd1);
      end
    join
    last_data = 32'h88776655;
    start_of(cyc + 1);

    // SB to IO with buffer full for cycles 1-3
    c0 = cyc;
    io_buffer_full = 1'b1;
    set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h30000, 32'h41);
    push(1'b1, last_data, c0 + 5);
    for (int unsigned k = 1; k <= 3; k++) begin
      at_cyc(c0 + k);
      check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
    end
    start_of(c0 + 4);
    io_buffer_full = 1'b0;
    at_cyc(c0 + 4);
    check("io_wr_c4", {31'd0, mem_wr}, 32'd1);
    check("io_addr_c4", mem_a, 32'h30000);
    check("io_dout_c4", {24'd0, mem_dout}, 32'h41);
    start_of(c0 + 6);
    clr_req(1'b1);
    check("io_ram", {24'd0, ram[18'h30000]}, 32'h41);

    // flush in cycle 3 of LW ch0: aborted, no response
    c0 = cyc;
    set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    start_of(c0 + 3);
    flush_in = 1'b1;
    start_of(c0 + 4);
    flush_in = 1'b0;
    clr_req(1'b0);
    at_cyc(c0 + 4);
    check("flush_rd_busy", {31'd0, busy_out}, 32'd0);
    start_of(c0 + 9);

    // flush during SW ch1: store completes
    c0 = cyc;
    set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA1B2C3D4);
    push(1'b1, last_data, c0 + 5);
    start_of(c0 + 2);
    flush_in = 1'b1;
    start_of(c0 + 3);
    flush_in = 1'b0;
    at_cyc(c0 + 4);
    check("sw_wr_c4", {31'd0, mem_wr}, 32'd1);
    check("sw_addr_c4", mem_a, 32'h403);
    check("sw_dout_c4", {24'd0, mem_dout}, 32'hA1);
    start_of(c0 + 6);
    clr_req(1'b1);
    check("sw_ram", {ram[18'h403], ram[18'h402], ram[18'h401], ram[18'h400]}, 32'hA1B2C3D4);

    // rdy_in low cycles 2-3 of LW: response delayed by two cycles
    c0 = cyc;
    set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    push(1'b0, 32'h44332211, c0 + 8);
    start_of(c0 + 2);
    rdy_in = 1'b0;
    start_of(c0 + 4);
    rdy_in = 1'b1;
    at_cyc(c0 + 7);
    check("rdy_busy_c7", {31'd0, busy_out}, 32'd1);
    start_of(c0 + 9);
    clr_req(1'b0);
    last_data = 32'h44332211;

    // reset in the middle of a SW: outputs return to reset values, no ack
    c0 = cyc;
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'h01020304);
    start_of(c0 + 2);
    rst_in = 1'b0;
    #1;
    check_reset_outputs();
    start_of(c0 + 3);
    clr_req(1'b0);
    rst_in = 1'b1;
    last_data = 32'd0;
    start_of(c0 + 8);

    // after reset ch0 wins a simultaneous request, ch1 follows
    c0 = cyc;
    set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h100, 32'd0);
    set_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h200, 32'd0);
    push(1'b0, 32'h00000011, c0 + 3);
    push(1'b1, 32'hFFFFFF80, c0 + 6);
    at_cyc(c0 + 1);
    check("post_rst_grant", {31'd0, grant_ch_out}, 32'd0);
    start_of(c0 + 4);
    clr_req(1'b0);
    start_of(c0 + 7);
    clr_req(1'b1);
    start_of(cyc + 3);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
